// File: rtl/vdma_wbuf_pkg.sv
// Shared buffer constants, FSM encoding and buffer-reference type for the
// video DMA write-buffer scheduler.
package vdma_wbuf_pkg;

  localparam int BUF_NUM       = 4;
  localparam int BUF_IDX_WIDTH = 2;

  typedef logic [BUF_IDX_WIDTH-1:0] buf_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  typedef struct packed {
    logic     valid;
    buf_idx_t idx;
  } buf_ref_t;

endpackage

// File: rtl/vdma_wbuf_scheduler_if.sv
// Core-facing bus of the write-buffer scheduler: frame address/geometry out,
// core status and acceptance index back.
interface vdma_wbuf_scheduler_if #(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int INDEX_WIDTH     = 8,
  parameter int STRIDE_WIDTH    = 14,
  parameter int H_WIDTH         = 12,
  parameter int V_WIDTH         = 12,
  parameter int AXI4_LEN_WIDTH  = 8
);
  logic                       core_enable;
  logic                       core_update;
  logic [AXI4_ADDR_WIDTH-1:0] core_addr;
  logic [STRIDE_WIDTH-1:0]    core_stride;
  logic [H_WIDTH-1:0]         core_width;
  logic [V_WIDTH-1:0]         core_height;
  logic [AXI4_LEN_WIDTH-1:0]  core_awlen;
  logic                       core_busy;
  logic [INDEX_WIDTH-1:0]     core_index;

  modport master (
    output core_enable, core_update, core_addr, core_stride, core_width,
           core_height, core_awlen,
    input  core_busy, core_index
  );

  modport slave (
    input  core_enable, core_update, core_addr, core_stride, core_width,
           core_height, core_awlen,
    output core_busy, core_index
  );
endinterface

// File: rtl/vdma_wbuf_free_pick.sv
// Combinational picker: lowest buffer index not claimed by any valid exclusion.
module vdma_wbuf_free_pick
  import vdma_wbuf_pkg::*;
(
  input  buf_idx_t excl_a_i,
  input  buf_idx_t excl_b_i,
  input  buf_idx_t excl_c_i,
  input  logic     valid_a_i,
  input  logic     valid_b_i,
  input  logic     valid_c_i,
  output buf_idx_t free_o
);

  // Scan downwards so the last hit, the lowest free index, wins.
  always_comb begin
    free_o = '0;
    for (int i = BUF_NUM - 1; i >= 0; i--) begin
      if (!(valid_a_i && (excl_a_i == buf_idx_t'(i))) &&
          !(valid_b_i && (excl_b_i == buf_idx_t'(i))) &&
          !(valid_c_i && (excl_c_i == buf_idx_t'(i)))) begin
        free_o = buf_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/vdma_wbuf_scheduler.sv
// Rotates four frame buffers between the write core (CUR/NXT), the newest
// complete frame (LATEST) and a reader lock (RD). Optional frame counter:
// define VDMA_WBUF_SCHEDULER_FRAME_CNT_EN.
module vdma_wbuf_scheduler
  import vdma_wbuf_pkg::*;
#(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int INDEX_WIDTH     = 8,
  parameter int STRIDE_WIDTH    = 14,
  parameter int H_WIDTH         = 12,
  parameter int V_WIDTH         = 12,
  parameter int AXI4_LEN_WIDTH  = 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       enable,
  output logic                       busy,
  input  logic [AXI4_ADDR_WIDTH-1:0] param_base,
  input  logic [AXI4_ADDR_WIDTH-1:0] param_size,
  input  logic [STRIDE_WIDTH-1:0]    param_stride,
  input  logic [H_WIDTH-1:0]         param_width,
  input  logic [V_WIDTH-1:0]         param_height,
  input  logic [AXI4_LEN_WIDTH-1:0]  param_awlen,
  vdma_wbuf_scheduler_if.master      core,
  input  logic                       rd_req,
  output logic [1:0]                 rd_buf,
  output logic [AXI4_ADDR_WIDTH-1:0] rd_addr,
  output logic                       rd_valid,
  output logic [1:0]                 wr_buf,
  output logic [15:0]                frame_count
);

  state_e                     state_q;
  logic                       busy_q;
  logic                       core_en_q;
  logic [AXI4_ADDR_WIDTH-1:0] base_q;
  logic [AXI4_ADDR_WIDTH-1:0] size_q;
  logic [STRIDE_WIDTH-1:0]    stride_q;
  logic [H_WIDTH-1:0]         width_q;
  logic [V_WIDTH-1:0]         height_q;
  logic [AXI4_LEN_WIDTH-1:0]  awlen_q;
  logic [AXI4_ADDR_WIDTH-1:0] core_addr_q;
  logic [AXI4_ADDR_WIDTH-1:0] rd_addr_q;
  buf_ref_t                   cur_q;
  buf_ref_t                   latest_q;
  buf_idx_t                   nxt_q;
  buf_idx_t                   rd_q;
  logic                       rd_valid_q;
  logic [INDEX_WIDTH-1:0]     prev_idx_q;
  logic                       prev_busy_q;

  logic                       acc;
  logic                       bfall;
  logic                       rd_take;
  buf_ref_t                   latest_d;
  buf_idx_t                   rd_d;
  logic                       rd_valid_d;
  buf_idx_t                   nxt_d;

  function automatic logic [AXI4_ADDR_WIDTH-1:0] buf_addr(
    input logic [AXI4_ADDR_WIDTH-1:0] base,
    input logic [AXI4_ADDR_WIDTH-1:0] size,
    input buf_idx_t                   idx
  );
    return base + size * AXI4_ADDR_WIDTH'(idx);
  endfunction

  // Values the buffer roles take after this edge; NXT must avoid all of them,
  // including a LATEST being locked by a simultaneous reader request.
  always_comb begin
    acc        = (state_q == RUN) && (core.core_index != prev_idx_q);
    bfall      = (state_q != IDLE) && prev_busy_q && !core.core_busy;
    rd_take    = rd_req && latest_q.valid;
    latest_d   = cur_q.valid ? cur_q : latest_q;
    rd_d       = rd_take ? latest_q.idx : rd_q;
    rd_valid_d = rd_valid_q | rd_take;
  end

  vdma_wbuf_free_pick u_free_pick (
    .excl_a_i  (nxt_q),
    .excl_b_i  (latest_d.idx),
    .excl_c_i  (rd_d),
    .valid_a_i (1'b1),
    .valid_b_i (latest_d.valid),
    .valid_c_i (rd_valid_d),
    .free_o    (nxt_d)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      core_en_q   <= 1'b0;
      base_q      <= '0;
      size_q      <= '0;
      stride_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      awlen_q     <= '0;
      core_addr_q <= '0;
      rd_addr_q   <= '0;
      cur_q       <= '0;
      latest_q    <= '0;
      nxt_q       <= '0;
      rd_q        <= '0;
      rd_valid_q  <= 1'b0;
      prev_idx_q  <= '0;
      prev_busy_q <= 1'b0;
    end else begin
      prev_idx_q  <= core.core_index;
      prev_busy_q <= core.core_busy;

      if (rd_take) begin
        rd_q       <= latest_q.idx;
        rd_valid_q <= 1'b1;
        rd_addr_q  <= buf_addr(base_q, size_q, latest_q.idx);
      end

      // Acceptance wins over a simultaneous busy falling edge.
      if (acc) begin
        latest_q <= latest_d;
        cur_q    <= '{valid: 1'b1, idx: nxt_q};
        nxt_q    <= nxt_d;
      end else if (bfall && cur_q.valid) begin
        latest_q    <= cur_q;
        cur_q.valid <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            core_en_q   <= 1'b1;
            base_q      <= param_base;
            size_q      <= param_size;
            stride_q    <= param_stride;
            width_q     <= param_width;
            height_q    <= param_height;
            awlen_q     <= param_awlen;
            cur_q.valid <= 1'b0;
            nxt_q       <= '0;
            core_addr_q <= param_base;
          end
        end
        RUN: begin
          core_addr_q <= buf_addr(base_q, size_q, nxt_q);
          if (!enable) begin
            state_q   <= STOP;
            core_en_q <= 1'b0;
          end
        end
        STOP: begin
          core_addr_q <= buf_addr(base_q, size_q, nxt_q);
          if (!core.core_busy) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VDMA_WBUF_SCHEDULER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt_q <= '0;
    end else if ((state_q == IDLE) && enable) begin
      frame_cnt_q <= '0;
    end else if ((acc || bfall) && cur_q.valid) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 16'd0;
`endif

  assign busy             = busy_q;
  assign core.core_enable = core_en_q;
  assign core.core_update = core_en_q;
  assign core.core_addr   = core_addr_q;
  assign core.core_stride = stride_q;
  assign core.core_width  = width_q;
  assign core.core_height = height_q;
  assign core.core_awlen  = awlen_q;
  assign rd_buf           = rd_q;
  assign rd_addr          = rd_addr_q;
  assign rd_valid         = rd_valid_q;
  assign wr_buf           = cur_q.valid ? cur_q.idx : nxt_q;

endmodule
